multicycle_controller: RTL
==========================

Name: multicycle_controller

Overview:
- Sequencing FSM for the RV32I core once it moves to a multicycle datapath with a single shared instruction/data memory.
- Decodes opcode/funct fields and drives every datapath select and enable, one step per clock.
- Handles memory wait states through a req/ready handshake.
- Sits beside the datapath in the CPU top level and replaces the combinational single-cycle control.

Parameters:
- RESET_STATE, 4'd0, state entered on reset (FETCH); exists only so benches can override it; synthesis keeps 0.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; forces FSM to FETCH immediately.
- opcode  input  7  instruction[6:0] from the instruction register.
- funct3  input  3  instruction[14:12].
- funct7b5  input  1  instruction[30].
- zero  input  1  ALU zero flag.
- mem_ready  input  1  memory completed the current access this cycle.
- mem_req  output  1  memory access request.
- mem_write  output  1  store strobe; valid only while mem_req=1.
- adr_src  output  1  memory address select: 0=PC, 1=ALU_out.
- IR_write  output  1  load the instruction register.
- PC_write  output  1  load the PC.
- reg_write  output  1  register file write enable.
- result_src  output  2  00=ALU_out, 01=read_data, 10=ALU_result.
- ALU_src_A  output  2  00=PC, 01=old_PC, 10=rs1.
- ALU_src_B  output  2  00=rs2, 01=imm_ext, 10=constant 4.
- imm_src  output  2  00=I, 01=S, 10=B, 11=J.
- ALU_control  output  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt.
- halted  output  1  illegal opcode trapped.

Behaviour:
- Outputs are Moore from state. Exceptions: ALU_control/imm_src are decoded from inputs; PC_write in BEQ depends on zero.
- Unlisted outputs are 0 in every state.
- Reset state is FETCH:
  - mem_req=1, IR_write=0, PC_write=0, reg_write=0, mem_write=0, halted=0.
  - All selects at their FETCH values.
- FETCH:
  - adr_src=0, mem_req=1, A=00, B=10, add, result_src=10.
  - IR_write=PC_write=mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE: A=01, B=01, add (branch target to ALU_out). Next state by opcode:
  - 0000011 or 0100011 -> MEM_ADR
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 1101111 -> JAL
  - 1100011 -> BEQ
  - anything else -> ILLEGAL
- MEM_ADR: A=10, B=01, add. Next is MEM_READ if opcode[5]=0, else MEM_WRITE.
- MEM_READ: adr_src=1, mem_req=1. Holds until mem_ready, then MEM_WB.
- MEM_WB: result_src=01, reg_write=1, then FETCH.
- MEM_WRITE: adr_src=1, mem_req=1, mem_write=1. Holds until mem_ready, then FETCH.
- EXEC_R: A=10, B=00, ALU op from funct fields, then ALU_WB.
- EXEC_I: A=10, B=01, ALU op from funct fields, then ALU_WB.
- ALU_WB: result_src=00, reg_write=1, then FETCH.
- JAL: A=01, B=10, add, result_src=00, PC_write=1, then ALU_WB (writes old_PC+4 to rd).
- BEQ: A=10, B=00, sub, result_src=00, PC_write=zero, then FETCH. funct3 is ignored (beq only).
- ILLEGAL: halted=1, all enables 0, mem_req=0. Sticky until reset.
- ALU decode:
  - FETCH/DECODE/MEM_ADR/JAL: add. BEQ: sub.
  - Execute states, by funct3:
    - 000: sub only if (opcode[5] & funct7b5), else add.
    - 010: slt. 100: xor. 110: or. 111: and.
    - Other funct3 values: add.
- imm_src is decoded from opcode in every state: I for 0000011/0010011, S 0100011, B 1100011, J 1101111, else 00.
- Reset asserted mid-access: FSM goes to FETCH asynchronously and mem_write drops the same instant. The interrupted access is abandoned.
- mem_ready while mem_req=0 is ignored.
- CPI with zero wait states:
  - lw 5, sw 4, R/I 4, jal 4, beq 3.
  - Each wait cycle adds 1.

Optional Feature:
- Macro CONTROLLER_INSTRET_EN.
- When defined: adds output instret[31:0].
  - Resets to 0.
  - Increments by 1 on the cycle the FSM leaves MEM_WB, MEM_WRITE (with mem_ready), ALU_WB or BEQ.
  - Wraps 0xFFFFFFFF -> 0.
  - Never counts in ILLEGAL.
- When undefined: no port and no counter logic.

Decomposition:
- Shared include cpu_defs.vh holds:
  - state encodings (4-bit localparams);
  - opcode constants;
  - ALU_control codes;
  - imm_src, result_src, ALU_src_A and ALU_src_B codes.
- One combinational sub-module, ALU_decoder, takes ALU_op[1:0], funct3, opcode[5] and funct7b5 and produces ALU_control. The FSM produces ALU_op: 00 add, 01 sub, 10 funct.

Test Plan:
- Reset mid-MEM_WRITE with mem_ready=0 -> mem_write=0 immediately; state=FETCH on release; mem_req=1.
- add x3,x1,x2 (opcode 0110011, funct3 000, funct7b5 0) with mem_ready always 1 -> FETCH, DECODE, EXEC_R, ALU_WB; reg_write=1 only in cycle 4; ALU_control=000; then sub variant gives 001.
- lw with mem_ready low 3 cycles in MEM_READ -> state held 4 cycles; mem_req=1, adr_src=1 throughout; MEM_WB follows with result_src=01.
- beq: zero=1 -> PC_write=1 in BEQ; zero=0 -> PC_write=0; both return to FETCH after 3 cycles.
- jal -> PC_write=1 in JAL, reg_write=1 in the next (ALU_WB) cycle, imm_src=11 in DECODE.
- opcode 1110011 -> ILLEGAL; halted=1, mem_req=0 for 10+ cycles until reset; with CONTROLLER_INSTRET_EN, instret unchanged.

Source files
------------

// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle RV32I controller: FSM states, opcodes, ALU codes and
// datapath select codes, plus the opcode-to-immediate-format decode.
package multicycle_controller_pkg;

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAdr   = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StExecR    = 4'd6,
        StExecI    = 4'd7,
        StAluWb    = 4'd8,
        StJal      = 4'd9,
        StBeq      = 4'd10,
        StIllegal  = 4'd11
    } state_e;

    localparam logic [6:0] OpLoad  = 7'b0000011;
    localparam logic [6:0] OpStore = 7'b0100011;
    localparam logic [6:0] OpRtype = 7'b0110011;
    localparam logic [6:0] OpItype = 7'b0010011;
    localparam logic [6:0] OpJal   = 7'b1101111;
    localparam logic [6:0] OpBeq   = 7'b1100011;

    localparam logic [2:0] AluAdd = 3'b000;
    localparam logic [2:0] AluSub = 3'b001;
    localparam logic [2:0] AluAnd = 3'b010;
    localparam logic [2:0] AluOr  = 3'b011;
    localparam logic [2:0] AluXor = 3'b100;
    localparam logic [2:0] AluSlt = 3'b101;

    localparam logic [1:0] AluOpAdd   = 2'b00;
    localparam logic [1:0] AluOpSub   = 2'b01;
    localparam logic [1:0] AluOpFunct = 2'b10;

    localparam logic [1:0] ImmI = 2'b00;
    localparam logic [1:0] ImmS = 2'b01;
    localparam logic [1:0] ImmB = 2'b10;
    localparam logic [1:0] ImmJ = 2'b11;

    localparam logic [1:0] ResAluOut    = 2'b00;
    localparam logic [1:0] ResReadData  = 2'b01;
    localparam logic [1:0] ResAluResult = 2'b10;

    localparam logic [1:0] SrcAPc    = 2'b00;
    localparam logic [1:0] SrcAOldPc = 2'b01;
    localparam logic [1:0] SrcARs1   = 2'b10;

    localparam logic [1:0] SrcBRs2  = 2'b00;
    localparam logic [1:0] SrcBImm  = 2'b01;
    localparam logic [1:0] SrcBFour = 2'b10;

    function automatic logic [1:0] imm_src_for(input logic [6:0] op);
        logic [1:0] imm;
        imm = ImmI;
        unique case (op)
            OpLoad, OpItype: imm = ImmI;
            OpStore:         imm = ImmS;
            OpBeq:           imm = ImmB;
            OpJal:           imm = ImmJ;
            default:         imm = ImmI;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// Combinational ALU decoder: maps the FSM's ALU_op plus funct fields onto ALU_control.
module multicycle_controller_alu_decoder
    import multicycle_controller_pkg::*;
(
    input  logic [1:0] alu_op_i,
    input  logic [2:0] funct3_i,
    input  logic       op5_i,
    input  logic       funct7b5_i,
    output logic [2:0] alu_control_o
);

    always_comb begin
        alu_control_o = AluAdd;
        unique case (alu_op_i)
            AluOpSub: alu_control_o = AluSub;
            AluOpFunct: begin
                unique case (funct3_i)
                    // bit 30 selects sub only for R-type; addi keeps it as immediate data
                    3'b000:  alu_control_o = (op5_i & funct7b5_i) ? AluSub : AluAdd;
                    3'b010:  alu_control_o = AluSlt;
                    3'b100:  alu_control_o = AluXor;
                    3'b110:  alu_control_o = AluOr;
                    3'b111:  alu_control_o = AluAnd;
                    default: alu_control_o = AluAdd;
                endcase
            end
            default: alu_control_o = AluAdd;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I sequencing FSM driving all datapath selects/enables with a req/ready memory.
// Define CONTROLLER_INSTRET_EN to add the retired-instruction counter output instret.
module multicycle_controller
    import multicycle_controller_pkg::*;
#(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       adr_src,
    output logic       IR_write,
    output logic       PC_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] ALU_src_A,
    output logic [1:0] ALU_src_B,
    output logic [1:0] imm_src,
    output logic [2:0] ALU_control,
    output logic       halted
`ifdef CONTROLLER_INSTRET_EN
    ,
    output logic [31:0] instret
`endif
);

    state_e     state_q, state_d;
    logic [1:0] alu_op;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= state_e'(RESET_STATE);
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        adr_src    = 1'b0;
        IR_write   = 1'b0;
        PC_write   = 1'b0;
        reg_write  = 1'b0;
        halted     = 1'b0;
        result_src = ResAluOut;
        ALU_src_A  = SrcAPc;
        ALU_src_B  = SrcBRs2;
        alu_op     = AluOpAdd;

        unique case (state_q)
            StFetch: begin
                mem_req    = 1'b1;
                // Held low while reset is asserted so nothing latches during reset.
                IR_write   = mem_ready & ~reset;
                PC_write   = mem_ready & ~reset;
                ALU_src_A  = SrcAPc;
                ALU_src_B  = SrcBFour;
                result_src = ResAluResult;
                if (mem_ready) begin
                    state_d = StDecode;
                end
            end
            StDecode: begin
                ALU_src_A = SrcAOldPc;
                ALU_src_B = SrcBImm;
                unique case (opcode)
                    OpLoad, OpStore: state_d = StMemAdr;
                    OpRtype:         state_d = StExecR;
                    OpItype:         state_d = StExecI;
                    OpJal:           state_d = StJal;
                    OpBeq:           state_d = StBeq;
                    default:         state_d = StIllegal;
                endcase
            end
            StMemAdr: begin
                ALU_src_A = SrcARs1;
                ALU_src_B = SrcBImm;
                state_d   = opcode[5] ? StMemWrite : StMemRead;
            end
            StMemRead: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                if (mem_ready) begin
                    state_d = StMemWb;
                end
            end
            StMemWb: begin
                result_src = ResReadData;
                reg_write  = 1'b1;
                state_d    = StFetch;
            end
            StMemWrite: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                adr_src   = 1'b1;
                if (mem_ready) begin
                    state_d = StFetch;
                end
            end
            StExecR: begin
                ALU_src_A = SrcARs1;
                ALU_src_B = SrcBRs2;
                alu_op    = AluOpFunct;
                state_d   = StAluWb;
            end
            StExecI: begin
                ALU_src_A = SrcARs1;
                ALU_src_B = SrcBImm;
                alu_op    = AluOpFunct;
                state_d   = StAluWb;
            end
            StAluWb: begin
                result_src = ResAluOut;
                reg_write  = 1'b1;
                state_d    = StFetch;
            end
            StJal: begin
                // ALU computes old_PC+4 for rd while PC takes the target held in ALU_out.
                ALU_src_A  = SrcAOldPc;
                ALU_src_B  = SrcBFour;
                result_src = ResAluOut;
                PC_write   = 1'b1;
                state_d    = StAluWb;
            end
            StBeq: begin
                ALU_src_A  = SrcARs1;
                ALU_src_B  = SrcBRs2;
                alu_op     = AluOpSub;
                result_src = ResAluOut;
                PC_write   = zero;
                state_d    = StFetch;
            end
            StIllegal: begin
                halted  = 1'b1;
                state_d = StIllegal;
            end
            default: state_d = StFetch;
        endcase
    end

    assign imm_src = imm_src_for(opcode);

    multicycle_controller_alu_decoder u_alu_decoder (
        .alu_op_i      (alu_op),
        .funct3_i      (funct3),
        .op5_i         (opcode[5]),
        .funct7b5_i    (funct7b5),
        .alu_control_o (ALU_control)
    );

`ifdef CONTROLLER_INSTRET_EN
    logic [31:0] instret_q;
    logic        retire;

    assign retire = (state_q == StMemWb) || (state_q == StAluWb) || (state_q == StBeq) ||
                    ((state_q == StMemWrite) && mem_ready);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            instret_q <= 32'd0;
        end else if (retire) begin
            instret_q <= instret_q + 32'd1;
        end
    end

    assign instret = instret_q;
`endif

endmodule
